uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART receiver/transmitter pair and an internal register bus.
//  Consumes bytes from rx_uart (single-cycle valid, no backpressure) and parses 'W' addr data / 'R' addr frames.
//  Issues single-cycle bus write/read strobes and returns one reply byte per command through tx_uart (valid/ready).
//  Aborts partial frames on inter-byte timeout; drops and flags bytes arriving while busy.
// PARAMETERS
//  TIMER_BITS      32        width of timeout counters
//  BYTE_TIMEOUT    17360     max clocks between frame bytes (20 baud @ 868 clk/baud) before abort
//  RD_TIMEOUT      255       max clocks from bus_re to bus_rvalid before error reply
// PORTS
//  clk          in   1  system clock; single clock domain
//  i_reset_n    in   1  synchronous reset, active low
//  rx_valid     in   1  one-cycle pulse: rx_data holds a received byte
//  rx_data      in   8  received byte
//  tx_valid     out  1  reply byte available for transmitter
//  tx_data      out  8  reply byte, stable while tx_valid && !tx_ready
//  tx_ready     in   1  transmitter accepts tx_data this cycle when tx_valid=1
//  bus_addr     out  8  register address, stable from strobe until return to IDLE
//  bus_wdata    out  8  write data
//  bus_we       out  1  one-cycle write strobe
//  bus_re       out  1  one-cycle read strobe
//  bus_rdata    in   8  read data, sampled when bus_rvalid=1
//  bus_rvalid   in   1  read data valid, >=1 cycle after bus_re
//  o_overrun    out  1  one-cycle pulse: rx byte dropped (ctrl busy)
//  o_abort      out  1  one-cycle pulse: partial frame discarded on byte timeout
// BEHAVIOUR
//  Reset (i_reset_n=0 at posedge): state=IDLE; tx_valid, bus_we, bus_re, o_overrun, o_abort=0; bus_addr, bus_wdata, tx_data=8'h00; counters cleared.
//  Reset mid-operation wins over everything; in-flight bus read is abandoned; late bus_rvalid is ignored in IDLE.
//  States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, REPLY.
//  IDLE: rx 8'h57 ('W') or 8'h52 ('R') -> GET_ADDR; any other byte -> tx_data=8'h3F ('?'), REPLY.
//  GET_ADDR: rx -> bus_addr; 'W' -> GET_DATA, 'R' -> BUS_RD.
//  GET_DATA: rx -> bus_wdata; -> BUS_WR.
//  BUS_WR: bus_we=1 exactly one cycle; tx_data=8'h4B ('K'); -> REPLY.
//  BUS_RD: bus_re=1 exactly one cycle; load read timer=RD_TIMEOUT; -> WAIT_RD.
//  WAIT_RD: bus_rvalid -> tx_data=bus_rdata, REPLY; timer reaches 0 first -> tx_data=8'hEE, REPLY.
//  WAIT_RD: bus_rvalid in the same cycle the timer reaches 0 -> data wins.
//  REPLY: tx_valid=1; on tx_valid&&tx_ready -> tx_valid=0 next cycle, IDLE.
//  Latency: last frame byte pulse -> bus_we at +1 cycle; -> tx_valid at +2 cycles.
//  Byte timer: reloads BYTE_TIMEOUT on every accepted byte; counts only in GET_ADDR/GET_DATA.
//  At 0: o_abort pulse, IDLE, no reply, no bus strobe.
//  rx_valid coincident with timer expiry: byte accepted, no abort.
//  rx_valid in BUS_WR/BUS_RD/WAIT_RD/REPLY: byte dropped, o_overrun=1 next cycle, state unaffected.
//  Exactly one reply per completed or rejected frame; never two bus strobes per frame.
// STRUCTURE
//  uart_cmd_defs.vh: opcode/reply localparams (CMD_WR 8'h57, CMD_RD 8'h52, RSP_OK 8'h4B, RSP_BAD 8'h3F, RSP_TMO 8'hEE), state encodings.
//  Sub-module cmd_timer (load, value, enable -> zero flag), instantiated twice (byte timeout, read timeout).
//  FSM, capture registers and reply register in uart_cmd_ctrl.
// TESTING
//  Write: rx 57,10,A5 -> one-cycle bus_we, addr=10, wdata=A5; tx 4B once; tx_ready held 0 for 5 clk keeps 4B stable.
//  Read: rx 52,22; bus_rdata=3C with rvalid 4 clk after bus_re -> tx 3C; bus_we never asserted.
//  Bad opcode: rx 41 -> tx 3F, no bus strobes. Read timeout: rvalid never -> tx EE after RD_TIMEOUT clk.
//  Abort: rx 57,10 then silence >BYTE_TIMEOUT -> o_abort pulse, no strobe, no tx. Then rx 52,10 decodes normally.
//  Overrun/reset: rx byte during REPLY -> o_overrun pulse, reply intact.
//  Reset in WAIT_RD -> all outputs 0 next clk; late rvalid produces no tx.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Opcode/reply byte values and FSM state encoding shared by the UART command controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_cmd_ctrl_pkg;

    // Command opcodes received over the UART
    localparam logic [7:0] CMD_WR  = 8'h57;   // 'W' addr data
    localparam logic [7:0] CMD_RD  = 8'h52;   // 'R' addr

    // Reply bytes returned over the UART
    localparam logic [7:0] RSP_OK  = 8'h4B;   // 'K' write completed
    localparam logic [7:0] RSP_BAD = 8'h3F;   // '?' unknown opcode
    localparam logic [7:0] RSP_TMO = 8'hEE;   // read data never arrived

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_BUS_WR   = 3'd3,
        S_BUS_RD   = 3'd4,
        S_WAIT_RD  = 3'd5,
        S_REPLY    = 3'd6
    } state_t;

endpackage

// File: rtl/cmd_timer.sv
// Loadable down-counter with a zero flag; used for the inter-byte and read-response timeouts.
// Latency: load takes effect on the next clock; zero_o is a decode of the registered count.
// Backpressure: none; counting simply stops at zero or while en_i is low.
//
// Ports:
//   clk        system clock
//   i_reset_n  synchronous reset, active low (count cleared, so zero_o=1)
//   load_i     load value_i this cycle (has priority over counting)
//   value_i    reload value
//   en_i       decrement by one per clock while non-zero
//   zero_o     count is zero
module cmd_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            // Saturate at zero so the flag stays up until the next load.
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 'W' addr data / 'R' addr frames from the UART, strobes the register bus, returns one reply byte.
// Latency: last frame byte -> bus strobe +1 clk; -> tx_valid +2 clk (write) / after bus_rvalid +1 clk (read).
// Backpressure: rx has none (bytes arriving while busy are dropped and flagged on o_overrun); tx holds until tx_ready.
//
// Ports:
//   clk, i_reset_n         clock, synchronous active-low reset
//   rx_valid, rx_data      one-cycle received-byte pulse
//   tx_valid, tx_data,     reply byte towards the transmitter (valid/ready)
//   tx_ready
//   bus_addr, bus_wdata,   register bus: address/write data held from strobe until IDLE,
//   bus_we, bus_re         one-cycle write/read strobes
//   bus_rdata, bus_rvalid  read return
//   o_overrun              one-cycle pulse: a byte was dropped because the controller was busy
//   o_abort                one-cycle pulse: a partial frame was discarded on inter-byte timeout
module uart_cmd_ctrl #(
    parameter int TIMER_BITS   = 32,
    parameter int BYTE_TIMEOUT = 17360,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rvalid,
    output logic       o_overrun,
    output logic       o_abort
);

    import uart_cmd_ctrl_pkg::*;

    localparam logic [TIMER_BITS-1:0] BYTE_TMO_VAL = TIMER_BITS'(BYTE_TIMEOUT);
    localparam logic [TIMER_BITS-1:0] RD_TMO_VAL   = TIMER_BITS'(RD_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] txd_q,   txd_d;
    logic       is_wr_q, is_wr_d;     // opcode of the frame being collected
    logic       overrun_q, overrun_d;
    logic       abort_q,   abort_d;

    logic       byte_load, byte_en, byte_zero;
    logic       rd_load,   rd_en,   rd_zero;

    // Inter-byte timeout: reloaded on each accepted byte, runs only while a frame is partial.
    cmd_timer #(
        .WIDTH (TIMER_BITS)
    ) u_byte_timer (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .load_i    (byte_load),
        .value_i   (BYTE_TMO_VAL),
        .en_i      (byte_en),
        .zero_o    (byte_zero)
    );

    // Read-response timeout: loaded with the read strobe, runs while waiting for bus_rvalid.
    cmd_timer #(
        .WIDTH (TIMER_BITS)
    ) u_rd_timer (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .load_i    (rd_load),
        .value_i   (RD_TMO_VAL),
        .en_i      (rd_en),
        .zero_o    (rd_zero)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        txd_d     = txd_q;
        is_wr_d   = is_wr_q;
        overrun_d = 1'b0;
        abort_d   = 1'b0;
        byte_load = 1'b0;
        byte_en   = 1'b0;
        rd_load   = 1'b0;
        rd_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        is_wr_d   = (rx_data == CMD_WR);
                        byte_load = 1'b1;
                        state_d   = S_GET_ADDR;
                    end else begin
                        txd_d   = RSP_BAD;
                        state_d = S_REPLY;
                    end
                end
            end

            S_GET_ADDR: begin
                byte_en = 1'b1;
                // A byte landing on the expiry cycle still counts: rx is checked first.
                if (rx_valid) begin
                    byte_load = 1'b1;
                    addr_d    = rx_data;
                    state_d   = is_wr_q ? S_GET_DATA : S_BUS_RD;
                end else if (byte_zero) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_GET_DATA: begin
                byte_en = 1'b1;
                if (rx_valid) begin
                    byte_load = 1'b1;
                    wdata_d   = rx_data;
                    state_d   = S_BUS_WR;
                end else if (byte_zero) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_BUS_WR: begin
                overrun_d = rx_valid;
                txd_d     = RSP_OK;
                state_d   = S_REPLY;
            end

            S_BUS_RD: begin
                overrun_d = rx_valid;
                rd_load   = 1'b1;
                state_d   = S_WAIT_RD;
            end

            S_WAIT_RD: begin
                overrun_d = rx_valid;
                rd_en     = 1'b1;
                // Data arriving on the expiry cycle wins over the timeout reply.
                if (bus_rvalid) begin
                    txd_d   = bus_rdata;
                    state_d = S_REPLY;
                end else if (rd_zero) begin
                    txd_d   = RSP_TMO;
                    state_d = S_REPLY;
                end
            end

            S_REPLY: begin
                overrun_d = rx_valid;
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            txd_q     <= 8'h00;
            is_wr_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            txd_q     <= txd_d;
            is_wr_q   <= is_wr_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    // Strobes are state decodes: each strobe state is occupied for exactly one cycle.
    assign bus_we    = (state_q == S_BUS_WR);
    assign bus_re    = (state_q == S_BUS_RD);
    assign tx_valid  = (state_q == S_REPLY);
    assign tx_data   = txd_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign o_overrun = overrun_q;
    assign o_abort   = abort_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    localparam int BYTE_TIMEOUT = 17360;
    localparam int RD_TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic       bus_rvalid;
    logic       o_overrun;
    logic       o_abort;

    int tests_run    = 0;
    int tests_failed = 0;

    // Event counters, sampled mid-cycle
    int we_cnt = 0, re_cnt = 0, tx_cnt = 0, abort_cnt = 0, ovr_cnt = 0;

    uart_cmd_ctrl #(
        .TIMER_BITS   (32),
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .RD_TIMEOUT   (RD_TIMEOUT)
    ) dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .o_overrun  (o_overrun),
        .o_abort    (o_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_we)              we_cnt    <= we_cnt + 1;
        if (bus_re)              re_cnt    <= re_cnt + 1;
        if (tx_valid && tx_ready) tx_cnt   <= tx_cnt + 1;
        if (o_abort)             abort_cnt <= abort_cnt + 1;
        if (o_overrun)           ovr_cnt   <= ovr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // One clock, then settle past the edge; inputs driven here are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic accept_reply();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        step();
        step();
        tests_run++; if (tx_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        tests_run++; if (bus_we !== 1'b0)    begin tests_failed++; $display("FAIL reset_bus_we got=%b exp=0", bus_we); end
        tests_run++; if (bus_re !== 1'b0)    begin tests_failed++; $display("FAIL reset_bus_re got=%b exp=0", bus_re); end
        tests_run++; if ({o_overrun, o_abort} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses got=%b exp=00", {o_overrun, o_abort}); end
        tests_run++; if ({bus_addr, bus_wdata, tx_data} !== 24'h0) begin tests_failed++; $display("FAIL reset_data got=%h exp=000000", {bus_addr, bus_wdata, tx_data}); end
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        int we0, tx0;
        logic held_ok;
        we0 = we_cnt; tx0 = tx_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'hA5);
        // One cycle after the last byte: write strobe
        tests_run++; if (bus_we !== 1'b1) begin tests_failed++; $display("FAIL wr_strobe got=%b exp=1", bus_we); end
        tests_run++; if ({bus_addr, bus_wdata} !== 16'h10A5) begin tests_failed++; $display("FAIL wr_addr_data got=%h exp=10a5", {bus_addr, bus_wdata}); end
        step();
        // Two cycles after: reply
        tests_run++; if ({tx_valid, bus_we, tx_data} !== 10'b10_0100_1011) begin tests_failed++; $display("FAIL wr_reply got tx_valid=%b bus_we=%b tx_data=%h exp 1,0,4b", tx_valid, bus_we, tx_data); end
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(tx_valid === 1'b1 && tx_data === 8'h4B)) held_ok = 1'b0;
        end
        tests_run++; if (held_ok !== 1'b1) begin tests_failed++; $display("FAIL wr_reply_hold got tx_valid=%b tx_data=%h exp 1,4b stable", tx_valid, tx_data); end
        accept_reply();
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_reply_drop got=%b exp=0", tx_valid); end
        tests_run++; if ((we_cnt - we0) != 1 || (tx_cnt - tx0) != 1) begin tests_failed++; $display("FAIL wr_counts got we=%0d tx=%0d exp 1,1", we_cnt - we0, tx_cnt - tx0); end
    endtask

    task automatic test_read();
        int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        send_byte(8'h52);
        send_byte(8'h22);
        tests_run++; if ({bus_re, bus_addr} !== 9'h122) begin tests_failed++; $display("FAIL rd_strobe got re=%b addr=%h exp 1,22", bus_re, bus_addr); end
        // bus_rvalid 4 clocks after the strobe cycle
        repeat (4) step();
        bus_rdata  = 8'h3C;
        bus_rvalid = 1'b1;
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = 8'h00;
        tests_run++; if ({tx_valid, tx_data} !== 9'h13C) begin tests_failed++; $display("FAIL rd_reply got valid=%b data=%h exp 1,3c", tx_valid, tx_data); end
        accept_reply();
        tests_run++; if ((we_cnt - we0) != 0 || (re_cnt - re0) != 1) begin tests_failed++; $display("FAIL rd_counts got we=%0d re=%0d exp 0,1", we_cnt - we0, re_cnt - re0); end
    endtask

    task automatic test_bad_opcode();
        int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        send_byte(8'h41);
        tests_run++; if ({tx_valid, tx_data} !== 9'h13F) begin tests_failed++; $display("FAIL bad_reply got valid=%b data=%h exp 1,3f", tx_valid, tx_data); end
        accept_reply();
        tests_run++; if ((we_cnt - we0) != 0 || (re_cnt - re0) != 0) begin tests_failed++; $display("FAIL bad_strobes got we=%0d re=%0d exp 0,0", we_cnt - we0, re_cnt - re0); end
    endtask

    task automatic test_read_timeout();
        int n;
        send_byte(8'h52);
        send_byte(8'h33);
        n = 0;
        while (tx_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        tests_run++; if (n < RD_TIMEOUT || n > RD_TIMEOUT + 3) begin tests_failed++; $display("FAIL rd_tmo_time got=%0d clk exp=%0d..%0d", n, RD_TIMEOUT, RD_TIMEOUT + 3); end
        tests_run++; if (tx_data !== 8'hEE) begin tests_failed++; $display("FAIL rd_tmo_data got=%h exp=ee", tx_data); end
        accept_reply();
    endtask

    // Timer loaded to RD_TIMEOUT in the first WAIT_RD cycle (strobe cycle + 1) and
    // decremented each cycle, so it reads zero RD_TIMEOUT+1 cycles after the strobe.
    task automatic test_rd_data_at_expiry();
        send_byte(8'h52);
        send_byte(8'h44);
        repeat (RD_TIMEOUT + 1) step();
        bus_rdata  = 8'h5A;
        bus_rvalid = 1'b1;
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = 8'h00;
        tests_run++; if ({tx_valid, tx_data} !== 9'h15A) begin tests_failed++; $display("FAIL rd_expiry_data got valid=%b data=%h exp 1,5a", tx_valid, tx_data); end
        accept_reply();
    endtask

    task automatic test_abort();
        int n, we0, re0, tx0, ab0;
        logic saw_tx;
        we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt; ab0 = abort_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        n = 0;
        saw_tx = 1'b0;
        while (o_abort !== 1'b1 && n < BYTE_TIMEOUT + 100) begin
            step();
            if (tx_valid) saw_tx = 1'b1;
            n++;
        end
        tests_run++; if (n < BYTE_TIMEOUT || n > BYTE_TIMEOUT + 3) begin tests_failed++; $display("FAIL abort_time got=%0d clk exp=%0d..%0d", n, BYTE_TIMEOUT, BYTE_TIMEOUT + 3); end
        step();
        tests_run++; if (o_abort !== 1'b0 || (abort_cnt - ab0) != 1) begin tests_failed++; $display("FAIL abort_pulse got o_abort=%b count=%0d exp 0,1", o_abort, abort_cnt - ab0); end
        tests_run++; if (saw_tx || (we_cnt - we0) != 0 || (re_cnt - re0) != 0 || (tx_cnt - tx0) != 0) begin tests_failed++; $display("FAIL abort_quiet got tx=%b we=%0d re=%0d exp 0,0,0", saw_tx, we_cnt - we0, re_cnt - re0); end
        // Next frame decodes normally
        send_byte(8'h52);
        send_byte(8'h10);
        tests_run++; if ({bus_re, bus_addr} !== 9'h110) begin tests_failed++; $display("FAIL abort_recover got re=%b addr=%h exp 1,10", bus_re, bus_addr); end
        step();
        bus_rdata  = 8'h77;
        bus_rvalid = 1'b1;
        step();
        bus_rvalid = 1'b0;
        tests_run++; if ({tx_valid, tx_data} !== 9'h177) begin tests_failed++; $display("FAIL abort_recover_reply got valid=%b data=%h exp 1,77", tx_valid, tx_data); end
        accept_reply();
    endtask

    // Byte timer is BYTE_TIMEOUT in the first GET_ADDR cycle and reads zero BYTE_TIMEOUT cycles later.
    task automatic test_byte_at_expiry();
        int ab0;
        ab0 = abort_cnt;
        send_byte(8'h57);
        repeat (BYTE_TIMEOUT) step();
        send_byte(8'h20);
        send_byte(8'h99);
        tests_run++; if ({bus_we, bus_addr, bus_wdata} !== 17'h12099) begin tests_failed++; $display("FAIL expiry_byte got we=%b addr=%h wdata=%h exp 1,20,99", bus_we, bus_addr, bus_wdata); end
        tests_run++; if ((abort_cnt - ab0) != 0) begin tests_failed++; $display("FAIL expiry_no_abort got=%0d exp=0", abort_cnt - ab0); end
        step();
        accept_reply();
    endtask

    task automatic test_overrun();
        int tx0;
        tx0 = tx_cnt;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h06);
        step();
        send_byte(8'h55);   // arrives during REPLY
        tests_run++; if (o_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_pulse got=%b exp=1", o_overrun); end
        tests_run++; if ({tx_valid, tx_data} !== 9'h14B) begin tests_failed++; $display("FAIL ovr_reply got valid=%b data=%h exp 1,4b", tx_valid, tx_data); end
        step();
        tests_run++; if (o_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_one_cycle got=%b exp=0", o_overrun); end
        accept_reply();
        repeat (3) step();
        tests_run++; if (tx_valid !== 1'b0 || (tx_cnt - tx0) != 1) begin tests_failed++; $display("FAIL ovr_single_reply got valid=%b replies=%0d exp 0,1", tx_valid, tx_cnt - tx0); end
    endtask

    task automatic test_reset_in_wait_rd();
        logic saw_tx;
        send_byte(8'h52);
        send_byte(8'h77);
        step();
        step();
        i_reset_n = 1'b0;
        step();
        tests_run++; if ({tx_valid, bus_we, bus_re, o_overrun, o_abort} !== 5'b0) begin tests_failed++; $display("FAIL rst_wait_ctrl got=%b exp=00000", {tx_valid, bus_we, bus_re, o_overrun, o_abort}); end
        tests_run++; if ({bus_addr, bus_wdata, tx_data} !== 24'h0) begin tests_failed++; $display("FAIL rst_wait_data got=%h exp=000000", {bus_addr, bus_wdata, tx_data}); end
        i_reset_n = 1'b1;
        bus_rdata  = 8'hAB;
        bus_rvalid = 1'b1;
        step();
        bus_rvalid = 1'b0;
        saw_tx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid) saw_tx = 1'b1;
            step();
        end
        tests_run++; if (saw_tx !== 1'b0) begin tests_failed++; $display("FAIL rst_late_rvalid got tx_valid seen=%b exp=0", saw_tx); end
    endtask

    initial begin
        i_reset_n  = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tx_ready   = 1'b0;
        bus_rdata  = 8'h00;
        bus_rvalid = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_read_timeout();
        test_rd_data_at_expiry();
        test_abort();
        test_byte_at_expiry();
        test_overrun();
        test_reset_in_wait_rd();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
